// File: rtl/data_mem_pipe.sv
// Byte-masked synchronous data memory for the MEM stage, with a fixed-latency
// read pipeline that carries valid, data and address-error flags.
module data_mem_pipe #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DATA_W-1:0]     write_data,
   input  logic [DATA_W/8-1:0]   byte_en,
   output logic [DATA_W-1:0]     read_data,
   output logic                  rd_valid,
   output logic                  addr_err
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic [IDX_W-1:0]  idx;
   logic              wr_en;
   logic [DATA_W-1:0] old_word;
   logic [DATA_W-1:0] new_word;
   logic [DATA_W-1:0] rd_word;

   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] err_q;
   logic [DATA_W-1:0] dat_q [RD_LAT];
   logic              wr_err_q;

   // Full-width compare so out-of-range addresses never alias into the array.
   assign in_range = ({1'b0, address} < DEPTH_X);
   assign idx      = address[IDX_W-1:0];
   assign wr_en    = mem_write && in_range;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      old_word = mem[idx];
      new_word = old_word;
      for (int i = 0; i < LANES; i++) begin
         if (byte_en[i]) new_word[8*i +: 8] = write_data[8*i +: 8];
      end
      rd_word = '0;
      if (in_range) rd_word = mem_write ? new_word : old_word;
   end

   // NOTE: the storage array has no reset; contents persist across rst_n and
   // only a live (rst_n high) in-range write may change them.
   always_ff @(posedge clk) begin
      if (rst_n && wr_en) mem[idx] <= new_word;
   end

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous-cycle value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         err_q    <= '0;
         wr_err_q <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= mem_read;
         err_q[0] <= mem_read && !in_range;
         if (mem_read) dat_q[0] <= rd_word;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
         // Write-only range errors report after one cycle regardless of RD_LAT.
         wr_err_q <= mem_write && !mem_read && !in_range;
      end
   end

   assign read_data = dat_q[RD_LAT-1];
   assign rd_valid  = vld_q[RD_LAT-1];
   assign addr_err  = err_q[RD_LAT-1] | wr_err_q;

endmodule
